// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
// Holds the FSM state enum, an index-width helper and a one-hot to index encoder.
// No logic of its own; imported by the picker and the arbiter top.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    // Index width for n entries, never narrower than one bit
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // One-hot (or zero) vector of up to 16 entries to its bit index; zero maps to 0
    function automatic logic [3:0] oh_to_idx(input logic [15:0] oh);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) r = r | 4'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Rotate-priority picker: first set bit of vec at or after ptr, wrapping to bit 0.
// Purely combinational, zero latency.
// No backpressure; valid is simply |vec.
module arb_rr_pick
    import arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  vec,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);

    logic [N-1:0] hi_mask;
    logic [N-1:0] hi_req;
    logic [N-1:0] sel;

    // Prefer requests at or above ptr; fall back to the full vector to wrap around
    always_comb begin
        hi_mask = '0;
        for (int i = 0; i < N; i++) begin
            hi_mask[i] = (i >= int'(ptr));
        end
        hi_req = vec & hi_mask;
        sel    = (|hi_req) ? hi_req : vec;
        onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (sel[i] && (onehot == '0)) onehot[i] = 1'b1;
        end
        valid = |vec;
        idx   = IW'(oh_to_idx(16'(onehot)));
    end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Shared-bus arbiter: PWB-first with a run limit, otherwise round-robin; hold and slow-unit minimum tenure.
// One cycle from request (bus idle) to registered grant; back-to-back tenures on release.
// Owner keeps the bus while hold[owner] is high or its minimum tenure has not expired.
module bus_arbiter_rr
    import arb_pkg::*;
#(
    parameter int                 NUM_REQ     = 4,
    parameter logic [NUM_REQ-1:0] SLOW_MASK   = 4'b1100,
    parameter int                 CYCLE_RATIO = 2,
    parameter int                 PWB_MAX     = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          pwb,
    input  logic [NUM_REQ-1:0]          hold,
    output logic [NUM_REQ-1:0]          grant,
    output logic [idx_w(NUM_REQ)-1:0]   grant_id,
    output logic                        bus_active
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int PW = idx_w(PWB_MAX + 1);
    localparam int TW = 4;

    arb_state_t      state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic            bus_active_q, bus_active_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]   pwb_run_q, pwb_run_d;
    logic [TW-1:0]   tenure_q, tenure_d;

    logic               pwb_valid, rr_valid;
    logic [IW-1:0]      pwb_idx, rr_idx, win_idx;
    logic [NUM_REQ-1:0] pwb_oh, rr_oh, win_oh;
    logic               rule1, any_req, arb_now;

    // Lowest-index priority write-back
    arb_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick_pwb (
        .vec    (req & pwb),
        .ptr    ('0),
        .valid  (pwb_valid),
        .idx    (pwb_idx),
        .onehot (pwb_oh)
    );

    // Round-robin over every request, starting at rr_ptr
    arb_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick_rr (
        .vec    (req),
        .ptr    (rr_ptr_q),
        .valid  (rr_valid),
        .idx    (rr_idx),
        .onehot (rr_oh)
    );

    // Winner selection and whether this cycle is an arbitration point
    always_comb begin
        rule1   = pwb_valid && (pwb_run_q < PW'(PWB_MAX));
        win_oh  = rule1 ? pwb_oh  : rr_oh;
        win_idx = rule1 ? pwb_idx : rr_idx;
        any_req = rr_valid;
        arb_now = (state_q == IDLE) || (!hold[grant_id_q] && (tenure_q == '0));
    end

    // State register plus output and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            grant_id_q   <= '0;
            bus_active_q <= 1'b0;
            rr_ptr_q     <= '0;
            pwb_run_q    <= '0;
            tenure_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            grant_id_q   <= grant_id_d;
            bus_active_q <= bus_active_d;
            rr_ptr_q     <= rr_ptr_d;
            pwb_run_q    <= pwb_run_d;
            tenure_q     <= tenure_d;
        end
    end

    // Next state: own the bus whenever an arbitration point sees a request
    always_comb begin
        state_d = state_q;
        if (arb_now) begin
            state_d = any_req ? OWN : IDLE;
        end
    end

    // Next values of the registered outputs and the fairness/tenure counters
    always_comb begin
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        pwb_run_d  = pwb_run_q;
        tenure_d   = ((state_q == OWN) && (tenure_q != '0)) ? tenure_q - 1'b1 : tenure_q;
        if (arb_now) begin
            if (any_req) begin
                grant_d    = win_oh;
                grant_id_d = win_idx;
                tenure_d   = SLOW_MASK[win_idx] ? TW'(CYCLE_RATIO - 1) : '0;
                if (rule1) begin
                    pwb_run_d = (pwb_run_q == PW'(PWB_MAX)) ? pwb_run_q : pwb_run_q + 1'b1;
                end else begin
                    pwb_run_d = '0;
                    rr_ptr_d  = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                end
            end else begin
                grant_d    = '0;
                grant_id_d = '0;
                tenure_d   = '0;
            end
        end
        bus_active_d = |grant_d;
    end

    assign grant      = grant_q;
    assign grant_id   = grant_id_q;
    assign bus_active = bus_active_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed sequences with literal expectations plus a random soak,
// all checked every cycle against a tenure-level model of the arbitration rules.
module tb_bus_arbiter_rr;

    localparam int         N    = 4;
    localparam int         IW   = 2;
    localparam logic [3:0] SLOW = 4'b1100;
    localparam int         CR   = 2;
    localparam int         PM   = 3;
    localparam int         WAIT_BOUND = (N - 1) * (1 + PM) + PM;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  pwb = '0;
    logic [N-1:0]  hold = '0;
    logic [N-1:0]  grant;
    logic [IW-1:0] grant_id;
    logic          bus_active;

    int n_chk  = 0;
    int n_fail = 0;

    bus_arbiter_rr #(
        .NUM_REQ     (N),
        .SLOW_MASK   (SLOW),
        .CYCLE_RATIO (CR),
        .PWB_MAX     (PM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .pwb        (pwb),
        .hold       (hold),
        .grant      (grant),
        .grant_id   (grant_id),
        .bus_active (bus_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- tenure-level model ----------------
    int m_owner = -1;   // -1: bus free
    int m_owned = 0;    // cycles the current owner has held the bus
    int m_ptr   = 0;
    int m_run   = 0;
    int waits [N];
    bit chk_en  = 1'b0;

    function automatic int min_len(input int i);
        return SLOW[IW'(i)] ? CR : 1;
    endfunction

    always @(posedge clk) begin
        int  w;
        bit  r1;
        bit  free;
        if (rst) begin
            m_owner = -1; m_owned = 0; m_ptr = 0; m_run = 0;
            for (int j = 0; j < N; j++) waits[j] = 0;
            chk_en = 1'b1;
        end else begin
            free = (m_owner < 0) || ((m_owned >= min_len(m_owner)) && !hold[IW'(m_owner)]);
            if (!free) begin
                m_owned++;
            end else if (req == '0) begin
                m_owner = -1;
                m_owned = 0;
            end else begin
                w  = -1;
                r1 = 1'b0;
                if (m_run < PM) begin
                    for (int j = 0; j < N; j++)
                        if (w < 0 && req[IW'(j)] && pwb[IW'(j)]) w = j;
                    r1 = (w >= 0);
                end
                if (w < 0) begin
                    for (int k = 0; k < N; k++)
                        if (w < 0 && req[IW'((m_ptr + k) % N)]) w = (m_ptr + k) % N;
                end
                for (int j = 0; j < N; j++) begin
                    if (j == w || !req[IW'(j)]) begin
                        waits[j] = 0;
                    end else begin
                        waits[j]++;
                        chk("wait_bound", 32'(waits[j] <= WAIT_BOUND), 32'd1);
                    end
                end
                m_owner = w;
                m_owned = 1;
                if (r1) begin
                    m_run++;
                end else begin
                    m_run = 0;
                    m_ptr = (w + 1) % N;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("grant",      32'(grant),      (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
            chk("grant_id",   32'(grant_id),   (m_owner < 0) ? 32'd0 : 32'(m_owner));
            chk("bus_active", 32'(bus_active), 32'(m_owner >= 0));
            chk("onehot0",    32'($onehot0(grant)), 32'd1);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        req = '0; pwb = '0; hold = '0; rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic expect_seq(input string nm, input logic [3:0] seq [], input int len);
        for (int i = 0; i < len; i++) begin
            tick();
            chk(nm, 32'(grant), 32'(seq[i]));
        end
    endtask

    logic [3:0] s1 [] = '{4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    logic [3:0] s2 [] = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
    logic [3:0] s3 [] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    logic [3:0] s4 [] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                          4'b0001, 4'b0100, 4'b0100};

    initial begin
        // 1: reset with all requesting, then rotation with slow tenures on 2 and 3
        req = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_rst_grant", 32'(grant), 32'd0);
            chk("t1_rst_active", 32'(bus_active), 32'd0);
        end
        rst = 1'b0;
        expect_seq("t1_rotate", s1, 7);

        // 2: two fast requesters alternate with no gaps
        do_reset();
        req = 4'b0011;
        expect_seq("t2_alt", s2, 6);

        // 3: hold keeps requester 0 on the bus; release hands over next edge
        do_reset();
        req = 4'b0011; hold = 4'b0001;
        expect_seq("t3_hold", s3, 5);
        hold = 4'b0000;
        tick();
        chk("t3_release", 32'(grant), 32'b0010);

        // 4: PWB run limit forces one ordinary grant
        do_reset();
        req = 4'b0101; pwb = 4'b0100;
        expect_seq("t4_pwb", s4, 9);

        // 5: slow requester keeps minimum tenure after dropping req
        do_reset();
        req = 4'b1000;
        tick();
        chk("t5_grant", 32'(grant), 32'b1000);
        chk("t5_id", 32'(grant_id), 32'd3);
        req = 4'b0000;
        tick();
        chk("t5_tenure", 32'(grant), 32'b1000);
        tick();
        chk("t5_free", 32'(grant), 32'd0);
        chk("t5_inactive", 32'(bus_active), 32'd0);

        // 6: random soak, requests held until granted, mid-run reset
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            if (c == 5000) begin
                rst = 1'b1;
                tick();
                chk("t6_rst_grant", 32'(grant), 32'd0);
                rst = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if (m_owner == i && $urandom_range(0, 3) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req[i] = 1'b1;
                end
            end
            pwb  = 4'($urandom);
            hold = 4'($urandom);
            if (m_owner >= 0) hold[IW'(m_owner)] = ($urandom_range(0, 3) == 0);
            tick();
        end

        req = '0; pwb = '0; hold = '0;
        tick(); tick(); tick();
        chk("final_idle", 32'(bus_active), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
